multisim_apb_arbiter: RTL

Round-robin arbiter that shares one APB manager port between `N_REQ` APB requesters. Each requester, typically a `multisim_client_apb_pull` instance driven by a different remote server, sees the arbiter as its subordinate. The arbiter forwards one transfer at a time to the shared manager port and routes the response back to the requester that issued it. An optional watchdog terminates transfers the subordinate never completes.

---
 rtl/multisim_apb_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/multisim_apb_arbiter.sv
`default_nettype none
// ============================================================================
// multisim_apb_arbiter: round-robin sharing of one APB manager port among
// N_REQ APB requesters, with an optional ACCESS-phase watchdog.
// Revision: 1.0
// ============================================================================
module multisim_apb_arbiter #(
  parameter int N_REQ      = 2,
  parameter int REQ_WIDTH  = 64,
  parameter int RESP_WIDTH = 33,
  parameter int TIMEOUT    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             i_s_psel,
  input  logic [N_REQ*REQ_WIDTH-1:0]   i_s_req,
  output logic [N_REQ-1:0]             o_s_pready,
  output logic [RESP_WIDTH-1:0]        o_s_resp,
  output logic                         o_s_timeout,
  output logic [REQ_WIDTH-1:0]         o_m_req,
  output logic                         o_m_psel,
  output logic                         o_m_penable,
  input  logic                         i_m_pready,
  input  logic [RESP_WIDTH-1:0]        i_m_resp
);

  localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] c_wdog_last = 16'(TIMEOUT - 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_idx_w-1:0]  r_ptr;
  logic [c_idx_w-1:0]  r_grant;
  logic [15:0]         r_wdog;

  logic [c_idx_w-1:0]  w_winner;
  logic [c_idx_w-1:0]  w_next_ptr;
  logic                w_expire;
  logic                w_done;
  logic [REQ_WIDTH-1:0] w_slice [N_REQ];

  // Scan from the highest offset down so the lowest offset after ptr wins.
  always_comb begin
    int idx;
    w_winner = r_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (i_s_psel[idx]) w_winner = c_idx_w'(idx);
    end
  end

  assign w_next_ptr = (r_grant == c_last_idx) ? '0 : r_grant + c_idx_w'(1);

  // A real pready in the expiry cycle wins over the watchdog.
  assign w_expire = (TIMEOUT != 0) && (r_state == S_ACCESS) &&
                    (r_wdog == c_wdog_last) && !i_m_pready;
  assign w_done   = (r_state == S_ACCESS) && (i_m_pready || w_expire);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign w_slice[i]    = i_s_req[i*REQ_WIDTH +: REQ_WIDTH];
      assign o_s_pready[i] = w_done && (r_grant == c_idx_w'(i));
    end
  endgenerate

  assign o_m_psel    = (r_state != S_IDLE);
  assign o_m_penable = (r_state == S_ACCESS);
  assign o_m_req     = (r_state != S_IDLE) ? w_slice[r_grant] : '0;
  assign o_s_timeout = w_expire;
  assign o_s_resp    = (r_state != S_ACCESS) ? '0 :
                       (w_expire ? '1 : i_m_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (|i_s_psel) begin
            r_grant <= w_winner;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: r_state <= S_ACCESS;
        S_ACCESS: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_wdog  <= '0;
            r_ptr   <= w_next_ptr;
          end else begin
            r_wdog  <= r_wdog + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
